// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller host port among NUM_PORTS
// requesters. One 16-bit read or write is in flight at a time. All outputs
// come straight from registers.
module ram_port_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int HADDR_WIDTH = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_PORTS-1:0]             i_req,
  input  logic [NUM_PORTS-1:0]             i_req_we,
  input  logic [NUM_PORTS*HADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i_req_wdata,
  output logic [NUM_PORTS-1:0]             o_ack,
  output logic [DATA_WIDTH-1:0]            o_rsp_rdata,
  output logic [IDX_WIDTH-1:0]             o_gnt_idx,
  input  logic                             i_mem_busy,
  input  logic                             i_mem_rd_ready,
  input  logic [DATA_WIDTH-1:0]            i_mem_rd_data,
  output logic                             o_mem_rd_enable,
  output logic [HADDR_WIDTH-1:0]           o_mem_rd_addr,
  output logic                             o_mem_wr_enable,
  output logic [HADDR_WIDTH-1:0]           o_mem_wr_addr,
  output logic [DATA_WIDTH-1:0]            o_mem_wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                   r_state, w_next;
  logic [IDX_WIDTH-1:0]     r_last, r_gnt;
  logic                     r_we;
  logic [HADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata, r_rdata;
  logic [NUM_PORTS-1:0]     r_ack;
  logic                     r_rd_en, r_wr_en;

  logic                     w_found, w_win_we;
  logic [IDX_WIDTH-1:0]     w_win;
  logic [HADDR_WIDTH-1:0]   w_win_addr;
  logic [DATA_WIDTH-1:0]    w_win_wdata;
  int                       w_best, w_dist;

  logic [NUM_PORTS-1:0]     w_ack;
  logic                     w_rd_en, w_wr_en, w_we, w_grant;
  logic [IDX_WIDTH-1:0]     w_gnt;
  logic [HADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]    w_wdata, w_rdata;

  // Round-robin pick: the requester closest after r_last (wrapping) wins.
  always_comb begin
    w_found     = 1'b0;
    w_win       = '0;
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    w_best      = NUM_PORTS;
    w_dist      = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_dist = (i + NUM_PORTS - 1 - int'(r_last)) % NUM_PORTS;
      if (i_req[i] && w_dist < w_best) begin
        w_best      = w_dist;
        w_found     = 1'b1;
        w_win       = IDX_WIDTH'(i);
        w_win_we    = i_req_we[i];
        w_win_addr  = i_req_addr[i*HADDR_WIDTH +: HADDR_WIDTH];
        w_win_wdata = i_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found && !i_mem_busy) w_next = S_ISSUE;
      S_ISSUE: if (i_mem_busy) w_next = S_WAIT;
      S_WAIT:  if (r_we ? !i_mem_busy : i_mem_rd_ready) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the latched request.
  always_comb begin
    w_grant = 1'b0;
    w_ack   = '0;
    w_rd_en = 1'b0;
    w_wr_en = 1'b0;
    w_gnt   = r_gnt;
    w_we    = r_we;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_rdata = r_rdata;
    case (r_state)
      S_IDLE: if (w_next == S_ISSUE) begin
        w_grant = 1'b1;
        w_gnt   = w_win;
        w_we    = w_win_we;
        w_addr  = w_win_addr;
        w_wdata = w_win_wdata;
        w_rd_en = !w_win_we;
        w_wr_en = w_win_we;
      end
      // Keep the enable up until the controller shows busy; an enable that
      // lands during refresh is not acknowledged with busy.
      S_ISSUE: if (!i_mem_busy) begin
        w_rd_en = !r_we;
        w_wr_en = r_we;
      end
      S_WAIT: if (w_next == S_DONE) begin
        w_ack = NUM_PORTS'(1) << r_gnt;
        if (!r_we) w_rdata = i_mem_rd_data;
      end
      default: ;
    endcase
  end

  // Output and request registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last  <= IDX_WIDTH'(NUM_PORTS - 1);
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= '0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
    end else begin
      if (w_grant) r_last <= w_win;
      r_gnt   <= w_gnt;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rdata <= w_rdata;
      r_ack   <= w_ack;
      r_rd_en <= w_rd_en;
      r_wr_en <= w_wr_en;
    end
  end

  assign o_ack           = r_ack;
  assign o_rsp_rdata     = r_rdata;
  assign o_gnt_idx       = r_gnt;
  assign o_mem_rd_enable = r_rd_en;
  assign o_mem_wr_enable = r_wr_en;
  assign o_mem_rd_addr   = r_addr;
  assign o_mem_wr_addr   = r_addr;
  assign o_mem_wr_data   = r_wdata;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares the single-port host interface of the SDRAM controller among NUM_PORTS requesters (e.g. video fetch, CPU, DMA).
- Each requester issues one 16-bit read or write at a time; the arbiter serialises the requests, drives the controller's rd/wr enable handshake and returns read data or write completion to the owning port.
- Sits between the requesters and the SDRAM controller; same clock domain as the controller.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- HADDR_WIDTH, 24, host address width {bank, row, col}.
- DATA_WIDTH, 16, data word width.
- IDX_WIDTH, 2, width of a port index; must be at least clog2(NUM_PORTS).

Ports:
- clk  in  1  system clock, same as the SDRAM controller.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_PORTS  per-port request; held high until ack.
- req_we  in  NUM_PORTS  per-port 1=write, 0=read; stable while req is high.
- req_addr  in  NUM_PORTS*HADDR_WIDTH  flattened; port i occupies slice i.
- req_wdata  in  NUM_PORTS*DATA_WIDTH  flattened write data.
- ack  out  NUM_PORTS  one-cycle completion pulse to the owning port.
- rsp_rdata  out  DATA_WIDTH  read data; valid in the ack cycle of a read.
- gnt_idx  out  IDX_WIDTH  index of the port currently or last served.
- mem_busy  in  1  controller busy.
- mem_rd_ready  in  1  controller read-data-valid pulse.
- mem_rd_data  in  DATA_WIDTH  controller read data.
- mem_rd_enable  out  1  controller read enable.
- mem_rd_addr  out  HADDR_WIDTH  controller read address.
- mem_wr_enable  out  1  controller write enable.
- mem_wr_addr  out  HADDR_WIDTH  controller write address.
- mem_wr_data  out  DATA_WIDTH  controller write data.

Behaviour:
- All outputs are registered. Reset takes effect synchronously on a rising clk edge with rst=1.
- Reset values:
  - state=IDLE.
  - ack, mem_rd_enable, mem_wr_enable = 0.
  - rsp_rdata, mem addresses, mem_wr_data, gnt_idx = 0.
  - round-robin pointer last=NUM_PORTS-1, so port 0 has first priority.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Arbitrate only when |req=1 and mem_busy=0.
  - Winner is the first asserted port searching last+1, last+2, ... modulo NUM_PORTS.
  - Latch winner index into gnt_idx and last, plus its we, addr and wdata. Go to ISSUE.
- ISSUE:
  - Drive mem_rd_enable=~we or mem_wr_enable=we, with the latched address on both mem_rd_addr and mem_wr_addr and the latched data on mem_wr_data.
  - Hold the enable every cycle until mem_busy=1 is sampled. Holding covers enables that land while the controller is in refresh, when busy is not raised.
  - When mem_busy=1 is sampled, deassert the enable on that edge and go to WAIT.
- WAIT:
  - Read: on mem_rd_ready=1, capture mem_rd_data into rsp_rdata and go to DONE.
  - Write: on mem_busy=0, go to DONE.
- DONE:
  - ack[gnt_idx]=1 for exactly one cycle, then go to IDLE.
  - rsp_rdata is held until the next read capture; it is unchanged by writes.
- Latency: the enable is asserted 1 cycle after req is sampled in IDLE. ack is asserted 1 cycle after completion is detected. Minimum gap between consecutive grants is 1 IDLE cycle.
- Requester rule: drop req (or present a new request) in the cycle after ack. req dropping mid-operation is ignored; the operation completes and ack is still pulsed.
- Simultaneous requests: exactly one grant per arbitration. A port that is just served gets lowest priority in the next arbitration. Every continuously requesting port is served within NUM_PORTS grants.
- mem_rd_ready seen during a write, or outside WAIT: ignored.
- Reset mid-operation: abort immediately to reset values and pulse no ack. The controller is reset alongside the arbiter.
- At most one of mem_rd_enable / mem_wr_enable is high in any cycle.

Test Plan:
- Single read: port 1 requests read of 24'h012345; mem_busy rises 2 cycles after the enable; mem_rd_ready arrives with data 16'hBEEF → mem_rd_enable held until busy is sampled, mem_rd_addr=24'h012345, then ack=4'b0010 for one cycle with rsp_rdata=16'hBEEF and gnt_idx=1.
- Single write: port 3 writes 16'hA5A5 to 24'h000010; busy is high for 5 cycles → mem_wr_data=16'hA5A5, mem_wr_addr=24'h000010, ack=4'b1000 one cycle after busy falls; rsp_rdata unchanged.
- Fairness: all 4 ports hold req continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3; exactly one ack per transaction.
- Delayed acceptance: mem_busy held at 0 for 20 cycles after ISSUE (controller in refresh) → enable stays high for all 20 cycles; no ack; completes normally once busy rises.
- Busy at arbitration: req[0]=1 while mem_busy=1 from a prior operation → no grant until mem_busy=0; grant follows on the next cycle.
- Reset mid-read: assert rst while in WAIT → next cycle all outputs are at reset values and no ack; after release, port 0 requesting alongside port 2 is granted first.
